// File: rtl/mmio_timer_gpio_pkg.sv
// Shared definitions for the MMIO timer/GPIO block.
// Holds the register offsets, the CTRL and STATUS bit positions, the reset
// values and a byte-lane merge helper. The SoC and the software headers use
// the same definitions.
package mmio_timer_gpio_pkg;

  // Word offsets, taken from data_addr[4:2]
  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_CNT    = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_CTRL   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  // CTRL / STATUS bit positions
  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_AUTORELOAD_BIT = 1;
  localparam int CTRL_IE_BIT         = 2;
  localparam int STATUS_MATCH_BIT    = 0;

  // Reset values
  localparam logic [3:0]  LED_RST    = 4'h0;
  localparam logic [31:0] CNT_RST    = 32'h0000_0000;
  localparam logic [31:0] CMP_RST    = 32'hFFFF_FFFF;
  localparam logic [2:0]  CTRL_RST   = 3'b000;
  localparam logic        STATUS_RST = 1'b0;

  typedef struct packed {
    logic ie;
    logic autoreload;
    logic en;
  } ctrl_t;

  // Replace only the bytes whose lane enable is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        r[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer_gpio_if.sv
// CPU data-port bundle for the MMIO timer/GPIO block.
//   data_addr  : byte address
//   data_wr    : write data
//   data_wr_en : byte-lane write enables
//   data_rd    : combinational read data
// The master modport is the CPU side. The slave modport is the peripheral side.
interface mmio_timer_gpio_if;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;
  logic [31:0] data_rd;

  modport master (output data_addr, output data_wr, output data_wr_en, input data_rd);
  modport slave  (input data_addr, input data_wr, input data_wr_en, output data_rd);
endinterface

// File: rtl/mmio_timer_gpio_prescaler.sv
// Timer prescaler: divides clk by PRESCALE while enabled.
//   clk, rst : system clock, asynchronous active-high reset
//   en_i     : count enable; when low, the phase is held at 0
//   tick_o   : high for one cycle on phase PRESCALE-1
module mmio_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;

  // tick_o depends only on the phase register and the registered enable
  assign tick_o = en_i && (phase_q == LAST);

  // Next phase: hold at 0 while disabled, wrap after the tick cycle
  always_comb begin
    phase_d = phase_q;
    if (!en_i) begin
      phase_d = '0;
    end else if (tick_o) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mmio_timer_gpio.sv
// Memory-mapped LED GPIO and 32-bit compare timer. The register window is
// 32 bytes at BASE_ADDR.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : CPU data port (slave modport), combinational read data
//   led      : LED register bits [3:0]
//   irq      : STATUS.match AND CTRL.ie
module mmio_timer_gpio
  import mmio_timer_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          PRESCALE  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  mmio_timer_gpio_if.slave   bus,
  output logic [3:0]         led,
  output logic               irq
);

  logic [3:0]  led_q,   led_d;
  logic [31:0] cnt_q,   cnt_d;
  logic [31:0] cmp_q,   cmp_d;
  ctrl_t       ctrl_q,  ctrl_d;
  logic        match_q, match_d;

  logic        hit;
  logic        wr;
  logic [2:0]  off;
  logic        tick;
  logic        cnt_eq;
  logic        match_set;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign hit       = (bus.data_addr[31:5] == BASE_ADDR[31:5]);
  assign wr        = hit && (bus.data_wr_en != 4'h0);
  assign off       = bus.data_addr[4:2];
  assign unused_ok = &{1'b1, bus.data_addr[1:0]};

  mmio_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ctrl_q.en),
    .tick_o (tick)
  );

  // The match check compares the registered CNT, before any write in this cycle
  assign cnt_eq    = (cnt_q == cmp_q);
  assign match_set = tick && cnt_eq;

  // Next-state logic: apply the tick first, then let a software write override it
  always_comb begin
    led_d   = led_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    match_d = match_q;

    if (tick) begin
      if (cnt_eq && ctrl_q.autoreload) begin
        cnt_d = 32'h0000_0000;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (wr) begin
      case (off)
        OFF_LED: begin
          if (bus.data_wr_en[0]) begin
            led_d = bus.data_wr[3:0];
          end else begin
            led_d = led_q;
          end
        end
        OFF_CNT:  cnt_d = merge_bytes(cnt_q, bus.data_wr, bus.data_wr_en);
        OFF_CMP:  cmp_d = merge_bytes(cmp_q, bus.data_wr, bus.data_wr_en);
        OFF_CTRL: begin
          if (bus.data_wr_en[0]) begin
            ctrl_d = ctrl_t'(bus.data_wr[2:0]);
          end else begin
            ctrl_d = ctrl_q;
          end
        end
        OFF_STATUS: begin
          if (bus.data_wr_en[0] && bus.data_wr[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
          end else begin
            match_d = match_q;
          end
        end
        default: begin
          led_d = led_q;
        end
      endcase
    end else begin
      led_d = led_q;
    end

    // A match set in the same cycle takes priority over the clear
    if (match_set) begin
      match_d = 1'b1;
    end else begin
      match_d = match_d;
    end
  end

  // Register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= LED_RST;
      cnt_q   <= CNT_RST;
      cmp_q   <= CMP_RST;
      ctrl_q  <= ctrl_t'(CTRL_RST);
      match_q <= STATUS_RST;
    end else begin
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
    end
  end

  // Read mux: combinational, side-effect free; misses, reserved offsets and unimplemented bits read 0
  always_comb begin
    rd_data = 32'h0000_0000;
    if (hit) begin
      case (off)
        OFF_LED:    rd_data = {28'h0, led_q};
        OFF_CNT:    rd_data = cnt_q;
        OFF_CMP:    rd_data = cmp_q;
        OFF_CTRL:   rd_data = {29'h0, ctrl_q};
        OFF_STATUS: rd_data = {31'h0, match_q};
        default:    rd_data = 32'h0000_0000;
      endcase
    end else begin
      rd_data = 32'h0000_0000;
    end
  end

  assign bus.data_rd = rd_data;
  assign led         = led_q;
  assign irq         = match_q && ctrl_q.ie;

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Self-checking bench for mmio_timer_gpio. A register-level model
// is compared every cycle, and directed steps add literal expectations.
module tb_mmio_timer_gpio;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          PS   = 4;

  typedef struct packed {
    logic [3:0]  led;
    logic [31:0] cnt;
    logic [31:0] cmp;
    logic        en;
    logic        ar;
    logic        ie;
    logic        match;
    int          phase;
  } model_t;

  localparam model_t RESET_M = '{led: 4'h0, cnt: 32'h0, cmp: 32'hFFFF_FFFF,
                                 en: 1'b0, ar: 1'b0, ie: 1'b0, match: 1'b0, phase: 0};

  logic clk = 1'b0;
  logic rst;
  logic [3:0] led;
  logic irq;
  int tests = 0;
  int fails = 0;
  model_t m = RESET_M;

  mmio_timer_gpio_if bus_if ();

  mmio_timer_gpio #(.BASE_ADDR(BASE), .PRESCALE(PS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave),
    .led (led),
    .irq (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // One clock of the register model
  function automatic model_t step(input model_t s, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    model_t n;
    bit tick, wr;
    int off;
    n    = s;
    tick = s.en && (s.phase == PS - 1);
    wr   = (a[31:5] == BASE[31:5]) && (be != 4'h0);
    off  = int'(a[4:2]);
    n.phase = s.en ? ((s.phase + 1) % PS) : 0;
    if (wr && off == 4 && be[0] && w[0]) n.match = 1'b0;
    if (tick) begin
      if (s.cnt == s.cmp) begin
        n.match = 1'b1;
        n.cnt = s.ar ? 32'h0 : s.cnt + 32'd1;
      end else begin
        n.cnt = s.cnt + 32'd1;
      end
    end
    if (wr) begin
      if (off == 0 && be[0]) n.led = w[3:0];
      if (off == 1) n.cnt = lanes(s.cnt, w, be);
      if (off == 2) n.cmp = lanes(s.cmp, w, be);
      if (off == 3 && be[0]) begin
        n.en = w[0]; n.ar = w[1]; n.ie = w[2];
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] model_rd(input model_t s, input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    case (int'(a[4:2]))
      0: return {28'h0, s.led};
      1: return s.cnt;
      2: return s.cmp;
      3: return {29'h0, s.ie, s.ar, s.en};
      4: return {31'h0, s.match};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state update
  always @(posedge clk or posedge rst) begin
    if (rst) m <= RESET_M;
    else     m <= step(m, bus_if.data_addr, bus_if.data_wr, bus_if.data_wr_en);
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("cyc_led", {28'h0, led}, {28'h0, m.led});
    check("cyc_irq", {31'h0, irq}, {31'h0, m.match & m.ie});
    check("cyc_rd", bus_if.data_rd, model_rd(m, bus_if.data_addr));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be);
    bus_if.data_addr  = BASE + 32'(off * 4);
    bus_if.data_wr    = d;
    bus_if.data_wr_en = be;
    @(posedge clk);
    #1;
    bus_if.data_wr_en = 4'h0;
  endtask

  task automatic rd_chk(input string name, input int off, input logic [31:0] exp);
    bus_if.data_addr  = BASE + 32'(off * 4);
    bus_if.data_wr_en = 4'h0;
    #1;
    check(name, bus_if.data_rd, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.data_addr  = 32'h0;
    bus_if.data_wr    = 32'h0;
    bus_if.data_wr_en = 4'h0;
    #1;
    check("rst_led", {28'h0, led}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rd_chk("rst_cmp", 2, 32'hFFFF_FFFF);
    rd_chk("rst_cnt", 1, 32'h0);
    // A write presented during reset is ignored
    bus_if.data_addr  = BASE;
    bus_if.data_wr    = 32'h5;
    bus_if.data_wr_en = 4'hF;
    cyc(2);
    bus_if.data_wr_en = 4'h0;
    check("rst_wr_ignored", {28'h0, led}, 32'h0);
    rst = 1'b0;
    cyc(1);

    // LED write and readback
    wr(0, 32'h0000_000A, 4'hF);
    check("led_a", {28'h0, led}, 32'hA);
    rd_chk("rd_led", 0, 32'h0000_000A);
    wr(0, 32'hFFFF_FFF5, 4'hF);
    rd_chk("led_unimpl", 0, 32'h0000_0005);

    // Byte-lane write into CMP
    wr(2, 32'h1122_3344, 4'hF);
    wr(2, 32'hAABB_CCDD, 4'h2);
    rd_chk("cmp_byte", 2, 32'h1122_CC44);

    // Autoreload match after 16 cycles
    wr(2, 32'h3, 4'hF);
    wr(3, 32'h7, 4'hF);
    cyc(15);
    check("irq_early", {31'h0, irq}, 32'h0);
    cyc(1);
    check("irq_16", {31'h0, irq}, 32'h1);
    rd_chk("cnt_reload", 1, 32'h0);
    rd_chk("status_1", 4, 32'h1);
    wr(4, 32'h1, 4'h1);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    wr(3, 32'h0, 4'hF);

    // Counter wrap, then match without autoreload
    wr(1, 32'hFFFF_FFFF, 4'hF);
    wr(2, 32'h0, 4'hF);
    wr(3, 32'h1, 4'hF);
    cyc(4);
    rd_chk("wrap_cnt", 1, 32'h0);
    rd_chk("wrap_nomatch", 4, 32'h0);
    cyc(4);
    rd_chk("noar_cnt", 1, 32'h1);
    rd_chk("noar_match", 4, 32'h1);
    check("irq_ie0", {31'h0, irq}, 32'h0);

    // CNT write coincident with a tick wins
    cyc(3);
    wr(1, 32'h55, 4'hF);
    rd_chk("cnt_write_wins", 1, 32'h55);
    wr(4, 32'h1, 4'h1);
    rd_chk("match_cleared", 4, 32'h0);
    wr(2, 32'h55, 4'hF);
    cyc(1);
    wr(4, 32'h1, 4'h1);
    rd_chk("set_beats_w1c", 4, 32'h1);
    rd_chk("cnt_56", 1, 32'h56);

    // Asynchronous reset mid-count
    wr(0, 32'hF, 4'hF);
    wr(3, 32'h7, 4'hF);
    cyc(1);
    check("pre_rst_led", {28'h0, led}, 32'hF);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    bus_if.data_addr = BASE + 32'h8;
    rst = 1'b1;
    #1;
    check("async_led", {28'h0, led}, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    check("async_cmp", bus_if.data_rd, 32'hFFFF_FFFF);
    bus_if.data_addr = 32'h0300_0000;
    #1;
    check("unmapped", bus_if.data_rd, 32'h0);
    cyc(2);
    rst = 1'b0;

    // First tick after reset comes PRESCALE cycles after en is set
    wr(3, 32'h1, 4'hF);
    cyc(3);
    rd_chk("post_rst_cnt0", 1, 32'h0);
    cyc(1);
    rd_chk("post_rst_cnt1", 1, 32'h1);
    wr(5, 32'hFFFF_FFFF, 4'hF);
    rd_chk("reserved", 5, 32'h0);
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmio_timer_gpio.md
MMIO_TIMER_GPIO -- requirements
Module: mmio_timer_gpio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, base of the 32-byte register window.
REQ-002 SHALL have parameter PRESCALE, default 1000, clk cycles per timer tick (>=1).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data_addr  input  32  byte address from cpu data port.
REQ-006 data_wr  input  32  write data.
REQ-007 data_wr_en  input  4  byte-lane write enables; bit n enables data_wr[8n+7:8n].
REQ-008 data_rd  output  32  read data for data_addr.
REQ-009 led  output  4  LED drive, equals LED register bits [3:0].
REQ-010 irq  output  1  timer interrupt, equals STATUS.match AND CTRL.ie.

Function
REQ-011 Hit SHALL be data_addr[31:5] == BASE_ADDR[31:5]; data_addr[1:0] ignored; register offset = data_addr[4:2].
REQ-012 Map: 0 LED (rw [3:0]); 1 CNT (rw 32); 2 CMP (rw 32); 3 CTRL (rw: bit0 en, bit1 autoreload, bit2 ie); 4 STATUS (bit0 match, write-1-to-clear); 5-7 reserved.
REQ-013 Write SHALL occur on the clk edge where hit and data_wr_en != 0; only enabled byte lanes update; unimplemented bits ignored.
REQ-014 data_rd SHALL be combinational from data_addr and current register state (zero-latency, single-cycle core); unimplemented bits, reserved offsets and non-hit addresses SHALL read 32'h0.
REQ-015 Reads SHALL have no side effects.
REQ-016 Prescaler SHALL count 0..PRESCALE-1 while CTRL.en=1, wrap to 0, and assert a one-cycle tick on the PRESCALE-1 cycle; CTRL.en=0 SHALL hold prescaler at 0 and suppress ticks.
REQ-017 On tick: if CNT==CMP, STATUS.match SHALL set and CNT SHALL become 0 when autoreload=1, else CNT+1; if CNT!=CMP, CNT SHALL become CNT+1, wrapping 32'hFFFF_FFFF -> 0.
REQ-018 Software write to CNT in a tick cycle SHALL win; the tick increment is dropped for that cycle (match check still uses pre-write CNT).
REQ-019 Match set and W1C of STATUS.match in the same cycle SHALL leave match=1.
REQ-020 Writing CTRL.en 1->0 SHALL freeze CNT immediately; 0->1 SHALL restart prescaler from 0.
REQ-021 led and irq SHALL be registered-state derived, no combinational path from data_* inputs.

Reset
REQ-022 rst=1 SHALL immediately force LED=0, CNT=0, CMP=32'hFFFF_FFFF, CTRL=0, STATUS=0, prescaler=0; hence led=0, irq=0.
REQ-023 Reset asserted mid-count SHALL discard any pending tick; first tick after release occurs PRESCALE cycles after en is set.
REQ-024 Writes presented during rst=1 SHALL be ignored.

Structure
REQ-025 Register offsets, CTRL/STATUS bit positions and reset values SHALL live in a shared package used by soc and software headers.
REQ-026 One sub-module SHALL exist: mmio_prescaler (PRESCALE parameter, en input, tick output); address decode, register file and read mux stay in mmio_timer_gpio.
REQ-027 soc SHALL connect data_rd and led from this block, removing its local LED register.

Verification
REQ-028 Write 32'h0000_000A to BASE+0 with data_wr_en=4'hF -> led=4'hA next cycle; read BASE+0 -> 32'h0000_000A.
REQ-029 Byte write: CMP=32'h1122_3344, then write 32'hAABB_CCDD with data_wr_en=4'h2 -> CMP reads 32'h1122_CC44.
REQ-030 PRESCALE=4, CMP=3, CTRL=3'b111 -> match and irq assert after 16 clk cycles, CNT reads 0; W1C STATUS=1 -> irq deasserts next cycle.
REQ-031 CNT=32'hFFFF_FFFF, CMP=0, autoreload=0, en=1 -> after one tick CNT=0, no match; after next tick match=1, CNT=1.
REQ-032 Tick coincident with CNT write of 32'h55 -> CNT reads 32'h55; coincident match and W1C -> match stays 1.
REQ-033 Assert rst mid-count with led=4'hF, irq=1 -> led=0, irq=0, data_rd for BASE+8 = 32'hFFFF_FFFF without waiting for a clk edge; unmapped address 32'h0300_0000 reads 0.
